// File: rtl/bnn_pkg.sv
// Shared BNN definitions: BPUG instruction field map, sequencer states
// and group geometry defaults.
package bnn_pkg;

    localparam int ADDR_W_DEF   = 10;
    localparam int N_BPU_DEF    = 8;
    localparam int WGT_ROWS_DEF = 7;

    localparam int INSTR_W     = 13;
    localparam int OP_LSB      = 0;
    localparam int OP_FW       = 5;
    localparam int DSEL_BIT    = 5;
    localparam int EN_LSB      = 6;
    localparam int EN_W        = 2;
    localparam int IMG_UP_BIT  = 8;
    localparam int IMG_SEL_BIT = 9;
    localparam int WSEL_LSB    = 10;
    localparam int WSEL_W      = 3;

    localparam logic [OP_FW-1:0] OP_NOP = 5'd0;

    localparam logic [EN_W-1:0] EN_NONE = 2'b00;
    localparam logic [EN_W-1:0] EN_WGT  = 2'b01;
    localparam logic [EN_W-1:0] EN_IMG  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_WGT,
        S_LD_IMG_LO,
        S_LD_IMG_HI,
        S_COMPUTE,
        S_SHIFT,
        S_FIN
    } seq_state_e;

    function automatic logic [INSTR_W-1:0] mk_instr(
        input logic [OP_FW-1:0]  op,
        input logic              dsel,
        input logic [EN_W-1:0]   en,
        input logic              up,
        input logic              isel,
        input logic [WSEL_W-1:0] wsel
    );
        logic [INSTR_W-1:0] r;
        r = '0;
        r[OP_LSB +: OP_FW]    = op;
        r[DSEL_BIT]           = dsel;
        r[EN_LSB +: EN_W]     = en;
        r[IMG_UP_BIT]         = up;
        r[IMG_SEL_BIT]        = isel;
        r[WSEL_LSB +: WSEL_W] = wsel;
        return r;
    endfunction

endpackage

// File: rtl/bpug_sequencer_if.sv
// Buffer read port plus the cycle-aligned BPUG instruction/data stream.
interface bpug_sequencer_if #(
    parameter int ADDR_W = bnn_pkg::ADDR_W_DEF
) ();

    logic                         rd_en;
    logic [ADDR_W-1:0]            rd_addr;
    logic [7:0]                   rd_data;
    logic                         sel;
    logic [bnn_pkg::INSTR_W-1:0]  instr;
    logic [7:0]                   data;

    modport master (
        output rd_en, rd_addr, sel, instr, data,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, sel, instr, data,
        output rd_data
    );

endinterface

// File: rtl/bpug_issue_stage.sv
// One-deep alignment register: holds the issued beat until its buffer
// data returns; a flush drops it.
module bpug_issue_stage
    import bnn_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               vld_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               load_i,
    input  logic               last_i,
    output logic               sel_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               load_o,
    output logic               last_o
);

    logic               sel_q;
    logic [INSTR_W-1:0] instr_q;
    logic               load_q;
    logic               last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= 1'b0;
            instr_q <= '0;
            load_q  <= 1'b0;
            last_q  <= 1'b0;
        end else if (flush_i) begin
            sel_q   <= 1'b0;
            instr_q <= '0;
            load_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            sel_q   <= vld_i;
            instr_q <= vld_i ? instr_i : '0;
            load_q  <= vld_i & load_i;
            last_q  <= vld_i & last_i;
        end
    end

    assign sel_o   = sel_q;
    assign instr_o = instr_q;
    assign load_o  = load_q;
    assign last_o  = last_q;

endmodule

// File: rtl/bpug_sequencer.sv
// BPUG issue sequencer: weight load, image load and row compute for
// one tile job, streamed into a single BPUG.
module bpug_sequencer
    import bnn_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int N_BPU    = N_BPU_DEF,
    parameter int WGT_ROWS = WGT_ROWS_DEF,
    parameter int OP_W     = OP_FW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [OP_W-1:0]   cfg_op,
    input  logic [3:0]        cfg_rows,
    input  logic [ADDR_W-1:0] cfg_wgt_base,
    input  logic [ADDR_W-1:0] cfg_img_base,
    bpug_sequencer_if.master  bus,
    output logic              busy,
    output logic              done
);

    localparam int NW = N_BPU * WGT_ROWS;
    localparam int KW = (NW > 16) ? $clog2(NW) : 4;
    localparam int WW = (WGT_ROWS > 2) ? $clog2(WGT_ROWS) : 1;

    localparam logic [KW-1:0] K_WLAST = KW'(NW - 1);
    localparam logic [KW-1:0] K_ILAST = KW'(7);
    localparam logic [WW-1:0] W_LAST  = WW'(WGT_ROWS - 1);

    seq_state_e         state_q;
    logic [KW-1:0]      k_q;
    logic [WW-1:0]      w_q;
    logic [WSEL_W-1:0]  b_q;
    logic               ph_q;
    logic [3:0]         row_q;

    logic [OP_W-1:0]    op_q;
    logic [3:0]         rows_q;
    logic [ADDR_W-1:0]  wbase_q;
    logic [ADDR_W-1:0]  ibase_q;

    logic               rd_en_q;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic               a_vld_q;
    logic               a_load_q;
    logic               a_last_q;
    logic [INSTR_W-1:0] a_instr_q;
    logic               done_q;

    logic               sel_s;
    logic               load_s;
    logic               last_s;
    logic [INSTR_W-1:0] instr_s;
    logic               kill;

    // Abort only acts while a job or its trailing beats are in flight.
    assign busy = (state_q != S_IDLE) | a_vld_q | sel_s;
    assign kill = abort & busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            w_q       <= '0;
            b_q       <= '0;
            ph_q      <= 1'b0;
            row_q     <= '0;
            op_q      <= '0;
            rows_q    <= '0;
            wbase_q   <= '0;
            ibase_q   <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            a_vld_q   <= 1'b0;
            a_load_q  <= 1'b0;
            a_last_q  <= 1'b0;
            a_instr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            rd_en_q   <= 1'b0;
            a_vld_q   <= 1'b0;
            a_load_q  <= 1'b0;
            a_last_q  <= 1'b0;
            a_instr_q <= '0;
            done_q    <= last_s & ~kill;
            if (kill) begin
                state_q <= S_IDLE;
                k_q     <= '0;
                w_q     <= '0;
                b_q     <= '0;
                ph_q    <= 1'b0;
                row_q   <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start && !busy) begin
                            op_q    <= cfg_op;
                            rows_q  <= cfg_rows;
                            wbase_q <= cfg_wgt_base;
                            ibase_q <= cfg_img_base;
                            k_q     <= '0;
                            w_q     <= '0;
                            b_q     <= '0;
                            state_q <= S_LD_WGT;
                        end
                    end
                    S_LD_WGT: begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= wbase_q + ADDR_W'(k_q);
                        a_vld_q   <= 1'b1;
                        a_load_q  <= 1'b1;
                        a_instr_q <= mk_instr(OP_NOP, 1'b0, EN_WGT,
                                              1'b0, 1'b0, b_q);
                        k_q       <= k_q + KW'(1);
                        if (w_q == W_LAST) begin
                            w_q <= '0;
                            b_q <= b_q + WSEL_W'(1);
                        end else begin
                            w_q <= w_q + WW'(1);
                        end
                        if (k_q == K_WLAST) begin
                            k_q     <= '0;
                            state_q <= S_LD_IMG_LO;
                        end
                    end
                    S_LD_IMG_LO: begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= ibase_q + ADDR_W'(k_q[2:0]);
                        a_vld_q   <= 1'b1;
                        a_load_q  <= 1'b1;
                        a_instr_q <= mk_instr(OP_NOP, 1'b0, EN_IMG,
                                              1'b0, 1'b0, '0);
                        k_q       <= k_q + KW'(1);
                        if (k_q == K_ILAST) begin
                            k_q     <= '0;
                            state_q <= S_LD_IMG_HI;
                        end
                    end
                    S_LD_IMG_HI: begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= ibase_q + ADDR_W'({1'b1, k_q[2:0]});
                        a_vld_q   <= 1'b1;
                        a_load_q  <= 1'b1;
                        a_instr_q <= mk_instr(OP_NOP, 1'b0, EN_IMG,
                                              1'b0, 1'b1, '0);
                        k_q       <= k_q + KW'(1);
                        if (k_q == K_ILAST) begin
                            k_q   <= '0;
                            ph_q  <= 1'b0;
                            row_q <= '0;
                            if (rows_q == 4'd0) begin
                                a_last_q <= 1'b1;
                                state_q  <= S_FIN;
                            end else begin
                                state_q  <= S_COMPUTE;
                            end
                        end
                    end
                    S_COMPUTE: begin
                        a_vld_q   <= 1'b1;
                        a_instr_q <= mk_instr(OP_FW'(op_q), ph_q, EN_NONE,
                                              1'b0, 1'b0, '0);
                        ph_q      <= ~ph_q;
                        if (ph_q) begin
                            state_q <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        a_vld_q   <= 1'b1;
                        a_instr_q <= mk_instr(OP_NOP, 1'b0, EN_NONE,
                                              1'b1, 1'b0, '0);
                        row_q     <= row_q + 4'd1;
                        ph_q      <= 1'b0;
                        if (row_q == rows_q - 4'd1) begin
                            a_last_q <= 1'b1;
                            state_q  <= S_FIN;
                        end else begin
                            state_q  <= S_COMPUTE;
                        end
                    end
                    S_FIN: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    bpug_issue_stage u_issue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (kill),
        .vld_i   (a_vld_q),
        .instr_i (a_instr_q),
        .load_i  (a_load_q),
        .last_i  (a_last_q),
        .sel_o   (sel_s),
        .instr_o (instr_s),
        .load_o  (load_s),
        .last_o  (last_s)
    );

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.sel     = sel_s;
    assign bus.instr   = instr_s;
    assign bus.data    = load_s ? bus.rd_data : 8'h00;
    assign done        = done_q;

endmodule

// File: tb/tb_bpug_sequencer.sv
// Directed bench for bpug_sequencer; the buffer model returns the low
// address byte one cycle after each read strobe.
module tb_bpug_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] cfg_op = '0;
    logic [3:0] cfg_rows = '0;
    logic [9:0] cfg_wgt_base = '0;
    logic [9:0] cfg_img_base = '0;
    logic       busy;
    logic       done;
    logic [9:0] addr_seen = '0;
    int         total = 0;
    int         bad = 0;

    bpug_sequencer_if #(.ADDR_W(10)) bus ();

    bpug_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .cfg_op       (cfg_op),
        .cfg_rows     (cfg_rows),
        .cfg_wgt_base (cfg_wgt_base),
        .cfg_img_base (cfg_img_base),
        .bus          (bus),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data <= bus.rd_addr[7:0];
            addr_seen   <= bus.rd_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [9:0] wb, input logic [9:0] ib,
                             input logic [3:0] rows, input logic [4:0] op);
        @(negedge clk);
        cfg_wgt_base = wb;
        cfg_img_base = ib;
        cfg_rows     = rows;
        cfg_op       = op;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_first(output bit ok);
        int w;
        w = 0;
        while (bus.sel !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        chk("first_beat_sel", bus.sel, 1);
        ok = (bus.sel === 1'b1);
    endtask

    task automatic run_beats(input logic [9:0] wb, input logic [9:0] ib,
                             input int rows, input logic [4:0] op,
                             input bit poke);
        int          n;
        bit          ok;
        bit          ld;
        logic [12:0] ei;
        logic [9:0]  ea;
        logic [7:0]  ed;
        n = 72 + 3 * rows;
        wait_first(ok);
        if (!ok) return;
        for (int i = 0; i < n; i++) begin
            ld = 1'b1;
            ea = '0;
            if (i < 56) begin
                ea = wb + 10'(i);
                ei = 13'h040 | (13'(i / 7) << 10);
            end else if (i < 64) begin
                ea = ib + 10'(i - 56);
                ei = 13'h080;
            end else if (i < 72) begin
                ea = ib + 10'(i - 56);
                ei = 13'h280;
            end else begin
                ld = 1'b0;
                case ((i - 72) % 3)
                    0:       ei = 13'(op);
                    1:       ei = 13'(op) | 13'h020;
                    default: ei = 13'h100;
                endcase
            end
            ed = ld ? ea[7:0] : 8'h00;
            chk($sformatf("instr[%0d]", i), bus.instr, ei);
            chk($sformatf("sel[%0d]", i), bus.sel, 1);
            chk($sformatf("busy[%0d]", i), busy, 1);
            chk($sformatf("data[%0d]", i), bus.data, ed);
            chk($sformatf("done_mid[%0d]", i), done, 0);
            if (ld) chk($sformatf("addr[%0d]", i), addr_seen, ea);
            if (poke && i == 10) begin
                start        = 1'b1;
                cfg_op       = 5'h1f;
                cfg_rows     = 4'd9;
                cfg_wgt_base = 10'h000;
            end
            if (poke && i == 11) start = 1'b0;
            @(negedge clk);
        end
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("sel_at_done", bus.sel, 0);
        chk("instr_at_done", bus.instr, 0);
        @(negedge clk);
        chk("done_once", done, 0);
    endtask

    initial begin
        bit ok;
        // reset with start held high
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sel", bus.sel, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_data", bus.data, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_sel", bus.sel, 0);

        // main job, with a start pulse and cfg changes mid-job
        start_job(10'h100, 10'h200, 4'd2, 5'h03);
        run_beats(10'h100, 10'h200, 2, 5'h03, 1'b1);

        // rows = 0 with address wrap
        start_job(10'h3fc, 10'h3f8, 4'd0, 5'h07);
        run_beats(10'h3fc, 10'h3f8, 0, 5'h07, 1'b0);

        // abort on LD_IMG_LO beat 3
        start_job(10'h040, 10'h080, 4'd1, 5'h03);
        wait_first(ok);
        repeat (59) @(negedge clk);
        chk("abort_pre_instr", bus.instr, 13'h080);
        chk("abort_pre_data", bus.data, 8'h83);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_instr", bus.instr, 0);
        chk("abort_sel", bus.sel, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", bus.rd_en, 0);
        chk("abort_data", bus.data, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("abort_nodone[%0d]", c), done, 0);
            chk($sformatf("abort_idle_sel[%0d]", c), bus.sel, 0);
        end

        // start and abort together in IDLE: start wins
        abort = 1'b1;
        start_job(10'h010, 10'h020, 4'd1, 5'h15);
        abort = 1'b0;
        run_beats(10'h010, 10'h020, 1, 5'h15, 1'b0);

        // asynchronous reset mid-job
        start_job(10'h000, 10'h000, 4'd3, 5'h03);
        repeat (20) @(negedge clk);
        chk("prereset_sel", bus.sel, 1);
        #2;
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        chk("areset_sel", bus.sel, 0);
        chk("areset_instr", bus.instr, 0);
        chk("areset_busy", busy, 0);
        chk("areset_done", done, 0);
        chk("areset_rd_en", bus.rd_en, 0);
        chk("areset_data", bus.data, 0);
        repeat (2) @(negedge clk);
        chk("reset_start_ignored", busy, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_sel", bus.sel, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
